// File: rtl/idli_sqi_mem_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_mem_m
// Purpose  : SQI (quad-SPI style) slave memory model. Decodes a 2-nibble
//            command, a 6-nibble address, optional dummy nibbles, then streams
//            read data out or write data in until chip select rises.
//            Commands: 0x03 = read, 0x02 = write, anything else is ignored.
// Ports    : i_mem_sck     - serial clock from initiator (sole clock)
//            rst_n         - asynchronous active-low reset
//            i_mem_cs      - chip select, low = selected; high aborts
//            i_mem_sio     - nibble from initiator (cmd / addr / write data)
//            o_mem_sio     - read-data nibble to initiator
//            o_mem_sio_en  - high while o_mem_sio is driven
//            o_mem_err     - sticky protocol-error flag
// Params   : ADDR_W    - byte-address width (depth 2**ADDR_W), 9..24
//            DUMMY_NIB - dummy nibbles between read address and data
// Options  : define IDLI_SQI_MEM_ERR_EN to enable error detection on
//            unsupported commands and out-of-range address bits.
// Revision : 1.0 - initial release
// ============================================================================
module idli_sqi_mem_m #(
  parameter int ADDR_W    = 17,
  parameter int DUMMY_NIB = 2
) (
  input  logic       i_mem_sck,
  input  logic       rst_n,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_en,
  output logic       o_mem_err
);

  // Nibble counter must reach 5 (address) and DUMMY_NIB-1 (dummy phase).
  localparam int CNT_W = (DUMMY_NIB > 6) ? $clog2(DUMMY_NIB) + 1 : 3;
  localparam logic [CNT_W-1:0] C_CMD_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ADDR_LAST  = CNT_W'(5);
  localparam logic [CNT_W-1:0] C_DUMMY_LAST = CNT_W'((DUMMY_NIB > 0) ? DUMMY_NIB - 1 : 0);

  // Only the upper address bits are needed when they are checked for errors;
  // otherwise the shifter keeps just enough bits to form the used address.
`ifdef IDLI_SQI_MEM_ERR_EN
  localparam int SH_W = 20;
`else
  localparam int SH_W = ADDR_W - 4;
`endif

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_ADDR   = 3'd1,
    S_DUMMY  = 3'd2,
    S_RD     = 3'd3,
    S_WR     = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_cmd_hi;
  logic                r_is_rd;
  logic [SH_W-1:0]     r_addr_sh;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_phase;     // 0 = high nibble next, 1 = low nibble next
  logic [3:0]          r_wr_hi;
  logic [7:0]          r_mem [2**ADDR_W];

  logic                w_clr_n;
  logic [7:0]          w_cmd;
  logic                w_cmd_ok;
  logic                w_cmd_last;
  logic [SH_W+3:0]     w_addr_full;
  logic                w_addr_last;
  logic                w_dummy_last;
  logic                w_wr_byte;
  logic [7:0]          w_rd_byte;

  // Chip select high behaves like a reset of all transaction state.
  assign w_clr_n      = rst_n & ~i_mem_cs;

  assign w_cmd        = {r_cmd_hi, i_mem_sio};
  assign w_cmd_ok     = (w_cmd == 8'h03) || (w_cmd == 8'h02);
  assign w_cmd_last   = (r_state == S_CMD)   && (r_cnt == C_CMD_LAST);
  assign w_addr_full  = {r_addr_sh, i_mem_sio};
  assign w_addr_last  = (r_state == S_ADDR)  && (r_cnt == C_ADDR_LAST);
  assign w_dummy_last = (r_state == S_DUMMY) && (r_cnt == C_DUMMY_LAST);
  assign w_wr_byte    = (r_state == S_WR)    && r_phase;
  assign w_rd_byte    = r_mem[r_addr];

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_mem_sck or negedge w_clr_n) begin
    if (!w_clr_n) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CMD: begin
        if (w_cmd_last) begin
          w_state_nxt = w_cmd_ok ? S_ADDR : S_IGNORE;
        end
      end
      S_ADDR: begin
        if (w_addr_last) begin
          if (!r_is_rd) begin
            w_state_nxt = S_WR;
          end else if (DUMMY_NIB == 0) begin
            w_state_nxt = S_RD;
          end else begin
            w_state_nxt = S_DUMMY;
          end
        end
      end
      S_DUMMY: begin
        if (w_dummy_last) begin
          w_state_nxt = S_RD;
        end
      end
      default: begin
        // RD, WR and IGNORE persist until chip select rises.
        w_state_nxt = r_state;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, command/address capture, byte phase, address advance
  // --------------------------------------------------------------------------
  always_ff @(posedge i_mem_sck or negedge w_clr_n) begin
    if (!w_clr_n) begin
      r_cnt     <= '0;
      r_cmd_hi  <= '0;
      r_is_rd   <= 1'b0;
      r_addr_sh <= '0;
      r_addr    <= '0;
      r_phase   <= 1'b0;
      r_wr_hi   <= '0;
    end else begin
      case (r_state)
        S_CMD: begin
          r_cmd_hi <= i_mem_sio;
          if (w_cmd_last) begin
            r_cnt   <= '0;
            r_is_rd <= (w_cmd == 8'h03);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ADDR: begin
          r_addr_sh <= w_addr_full[SH_W-1:0];
          if (w_addr_last) begin
            r_cnt  <= '0;
            r_addr <= w_addr_full[ADDR_W-1:0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DUMMY: begin
          r_cnt <= w_dummy_last ? '0 : r_cnt + CNT_W'(1);
        end
        S_RD: begin
          // Each rising edge consumes the nibble presented on the prior fall.
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_WR: begin
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_wr_hi <= i_mem_sio;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory array: not reset. A byte is committed only on its second nibble,
  // so an abort after one nibble leaves the array untouched.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_mem_sck) begin
    if (w_wr_byte) begin
      r_mem[r_addr] <= {r_wr_hi, i_mem_sio};
    end
  end

  // --------------------------------------------------------------------------
  // Read output: updated on the falling edge so data is stable at the next
  // rising edge where the initiator samples it.
  // --------------------------------------------------------------------------
  always_ff @(negedge i_mem_sck or negedge w_clr_n) begin
    if (!w_clr_n) begin
      o_mem_sio    <= 4'h0;
      o_mem_sio_en <= 1'b0;
    end else if (r_state == S_RD) begin
      o_mem_sio    <= r_phase ? w_rd_byte[3:0] : w_rd_byte[7:4];
      o_mem_sio_en <= 1'b1;
    end else begin
      o_mem_sio    <= 4'h0;
      o_mem_sio_en <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional sticky error flag (cleared only by rst_n, not by chip select)
  // --------------------------------------------------------------------------
`ifdef IDLI_SQI_MEM_ERR_EN
  logic w_addr_hi_nz;
  logic r_err;

  if (ADDR_W < 24) begin : g_addr_hi_chk
    assign w_addr_hi_nz = |w_addr_full[23:ADDR_W];
  end else begin : g_addr_hi_none
    assign w_addr_hi_nz = 1'b0;
  end

  always_ff @(posedge i_mem_sck or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((w_cmd_last && !w_cmd_ok) || (w_addr_last && w_addr_hi_nz)) begin
      r_err <= 1'b1;
    end
  end

  assign o_mem_err = r_err;
`else
  assign o_mem_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_mem_m.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_idli_sqi_mem_m
// Purpose  : Self-checking bench for idli_sqi_mem_m. Directed transactions
//            push expected read nibbles into a queue; a monitor pops and
//            compares them whenever the DUT drives o_mem_sio_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_mem_m;

  localparam int ADDR_W    = 17;
  localparam int DUMMY_NIB = 2;
`ifdef IDLI_SQI_MEM_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       cs    = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] o_sio;
  logic       o_en;
  logic       o_err;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  idli_sqi_mem_m #(
    .ADDR_W    (ADDR_W),
    .DUMMY_NIB (DUMMY_NIB)
  ) u_dut (
    .i_mem_sck    (clk),
    .rst_n        (rst_n),
    .i_mem_cs     (cs),
    .i_mem_sio    (sio_in),
    .o_mem_sio    (o_sio),
    .o_mem_sio_en (o_en),
    .o_mem_err    (o_err)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    #1;
    cs     = 1'b0;
    sio_in = n;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic cs_high();
    @(negedge clk);
    #1;
    cs     = 1'b1;
    sio_in = 4'h0;
    @(negedge clk);
  endtask

  task automatic header(input logic [7:0] cmd, input logic [23:0] addr);
    send_byte(cmd);
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
  endtask

  // Write n (1 or 2) bytes: d[15:8] first, then d[7:0].
  task automatic wr(input logic [23:0] addr, input logic [15:0] d, input int n);
    header(8'h02, addr);
    send_byte(d[15:8]);
    if (n > 1) send_byte(d[7:0]);
    cs_high();
  endtask

  // Read n (1 or 2) bytes, expecting exp[15:8] then exp[7:0].
  task automatic rd(input logic [23:0] addr, input logic [15:0] exp, input int n);
    exp_q.push_back(exp[15:12]);
    exp_q.push_back(exp[11:8]);
    if (n > 1) begin
      exp_q.push_back(exp[7:4]);
      exp_q.push_back(exp[3:0]);
    end
    header(8'h03, addr);
    repeat (DUMMY_NIB) send_nib(4'h0);
    repeat (2 * n) send_nib(4'h0);
    cs_high();
  endtask

  // Monitor: outputs change on the falling edge, sampled here on the rising.
  initial begin
    forever begin
      @(posedge clk);
      if (o_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %0h expected no output", o_sio);
        end else begin
          chk("rd_nibble", {4'h0, o_sio}, {4'h0, exp_q.pop_front()});
        end
      end else begin
        chk("idle_sio_zero", {4'h0, o_sio}, 8'h00);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("reset_sio", {4'h0, o_sio}, 8'h00);
    chk("reset_en",  {7'h0, o_en},  8'h00);
    chk("reset_err", {7'h0, o_err}, 8'h00);
    @(negedge clk);

    // Basic write then read-back.
    wr(24'h000010, 16'hA53C, 2);
    rd(24'h000010, 16'hA53C, 2);

    // Address wrap from top of array to 0.
    wr(24'h01FFFF, 16'h1122, 2);
    rd(24'h000000, 16'h2200, 1);
    rd(24'h01FFFF, 16'h1100, 1);
    rd(24'h01FFFF, 16'h1122, 2);
    chk("err_after_valid", {7'h0, o_err}, 8'h00);

    // Abort of a half-written byte keeps the prior value.
    wr(24'h000020, 16'h5A00, 1);
    header(8'h02, 24'h000020);
    send_nib(4'hF);
    cs_high();
    rd(24'h000020, 16'h5A00, 1);

    // Unsupported command; trailing nibbles would write 0x55 to 0x10 if
    // wrongly decoded as a write.
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h55);
    chk("badcmd_en", {7'h0, o_en}, 8'h00);
    cs_high();
    chk("badcmd_err", {7'h0, o_err}, {7'h0, ERR_ON});
    rd(24'h000010, 16'hA53C, 2);
    chk("err_sticky", {7'h0, o_err}, {7'h0, ERR_ON});

    // Reset in the middle of a read burst after three data nibbles.
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h3);
    header(8'h03, 24'h000010);
    repeat (DUMMY_NIB) send_nib(4'h0);
    repeat (3) send_nib(4'h0);
    @(negedge clk);
    #1;
    chk("pre_reset_sio", {4'h0, o_sio}, 8'h0C);
    rst_n = 1'b0;
    cs    = 1'b1;
    #1;
    chk("midrd_rst_sio", {4'h0, o_sio}, 8'h00);
    chk("midrd_rst_en",  {7'h0, o_en},  8'h00);
    chk("midrd_rst_err", {7'h0, o_err}, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    rd(24'h000010, 16'hA53C, 2);

    // Address bits above ADDR_W are discarded but flagged.
    wr(24'h000004, 16'h9600, 1);
    chk("err_clean", {7'h0, o_err}, 8'h00);
    rd(24'h820004, 16'h9600, 1);
    chk("addr_hi_err", {7'h0, o_err}, {7'h0, ERR_ON});

    repeat (4) @(negedge clk);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
